// File: rtl/ram_arbiter_n_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter_n_pkg
// Description : Shared constants, state encodings and helpers for ram_arbiter_n.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_arbiter_n_pkg;

    localparam int ADDR_W_DEF  = 32;
    localparam int MAX_LEN_DEF = 4;
    localparam int LEN_W       = 3;

    typedef logic [LEN_W-1:0] len_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;

    // Memory-mapped IO lives where addr[17:16] == 2'b11
    localparam logic [1:0] IO_REGION = 2'b11;

    function automatic logic is_io(input logic [1:0] i_addr_hi);
        return i_addr_hi == IO_REGION;
    endfunction

    function automatic len_t clamp_len(input len_t i_len, input int i_max);
        if (int'(i_len) > i_max)
            return len_t'(i_max);
        return i_len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ram_arbiter_n_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter_n_rr_arbiter
// Description : One-hot read-channel arbiter. ARB_ROUND_ROBIN_EN selects
//               round-robin; otherwise fixed priority, lowest index wins.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_arbiter_n_rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] i_req,
    input  logic         i_adv,
    output logic [N-1:0] o_gnt
);

    localparam int ID_W = (N > 1) ? $clog2(N) : 1;

    logic [ID_W-1:0] r_ptr;
    logic [ID_W-1:0] w_ptr_nxt;
    logic            w_found;

    always_comb begin
        int idx;
        idx       = 0;
        o_gnt     = '0;
        w_ptr_nxt = r_ptr;
        w_found   = 1'b0;
        for (int off = 0; off < N; off++) begin
            idx = (int'(r_ptr) + off) % N;
            if (!w_found && i_req[idx]) begin
                o_gnt[idx] = 1'b1;
                w_ptr_nxt  = ID_W'((idx + 1) % N);
                w_found    = 1'b1;
            end
        end
`ifndef ARB_ROUND_ROBIN_EN
        // Fixed priority: the scan always starts from channel 0
        w_ptr_nxt = '0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_ptr <= '0;
        else if (i_adv && w_found)
            r_ptr <= w_ptr_nxt;
    end

endmodule
`default_nettype wire

// File: rtl/ram_arbiter_n.sv
`default_nettype none
// ============================================================================
// Module      : ram_arbiter_n
// Description : Byte-serial RAM arbiter, NUM_RD read channels + one write
//               channel. Optional macro ARB_ROUND_ROBIN_EN: round-robin reads.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_arbiter_n
    import ram_arbiter_n_pkg::*;
#(
    parameter int NUM_RD  = 2,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int MAX_LEN = MAX_LEN_DEF
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     hold,
    input  logic [NUM_RD-1:0]        rd_req,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    input  logic [NUM_RD*3-1:0]      rd_len,
    input  logic [NUM_RD-1:0]        rd_signed,
    input  logic [NUM_RD-1:0]        rd_discard,
    output logic [NUM_RD-1:0]        rd_done,
    output logic [8*MAX_LEN-1:0]     rd_data,
    input  logic                     wr_req,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [2:0]               wr_len,
    input  logic [8*MAX_LEN-1:0]     wr_data,
    output logic                     wr_done,
    output logic [ADDR_W-1:0]        mem_a,
    output logic                     mem_wr,
    output logic [7:0]               mem_dout,
    input  logic [7:0]               mem_din
);

    localparam int ID_W = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
    localparam int DW   = 8 * MAX_LEN;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    len_t              r_len, r_k, r_pidx;
    logic              r_signed, r_pend, r_wr_done;
    logic [ID_W-1:0]   r_id;
    logic [DW-1:0]     r_buf, r_rd_data;
    logic [NUM_RD-1:0] r_rd_done;

    logic              w_idle_go, w_wr_go, w_rd_go, w_issue, w_discard;
    logic              w_rd_fin, w_wr_fin, w_sgn, w_gnt_sgn;
    logic [NUM_RD-1:0] w_rd_req_m, w_gnt;
    logic [ID_W-1:0]   w_gnt_id;
    logic [ADDR_W-1:0] w_gnt_addr;
    len_t              w_gnt_len;
    logic [7:0]        w_byte;
    logic [DW-1:0]     w_final, w_ext;

    // Done pulses are held back while hold is high
    assign rd_done = hold ? '0 : r_rd_done;
    assign wr_done = r_wr_done & ~hold;
    assign rd_data = r_rd_data;

    assign w_idle_go  = (r_state == ST_IDLE) && !hold;
    assign w_wr_go    = w_idle_go && wr_req && !wr_done;
    assign w_rd_req_m = (w_idle_go && !w_wr_go) ? (rd_req & ~rd_done) : '0;
    assign w_rd_go    = |w_gnt;

    ram_arbiter_n_rr_arbiter #(.N(NUM_RD)) u_arb (
        .clk   (clock),
        .rst_n (reset),
        .i_req (w_rd_req_m),
        .i_adv (w_rd_go),
        .o_gnt (w_gnt)
    );

    always_comb begin
        w_gnt_id   = '0;
        w_gnt_addr = '0;
        w_gnt_len  = '0;
        w_gnt_sgn  = 1'b0;
        w_discard  = 1'b0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (w_gnt[i]) begin
                w_gnt_id   = ID_W'(i);
                w_gnt_addr = rd_addr[i*ADDR_W +: ADDR_W];
                w_gnt_len  = rd_len[i*3 +: 3];
                w_gnt_sgn  = rd_signed[i];
            end
            if (r_state == ST_READ && ID_W'(i) == r_id)
                w_discard = rd_discard[i];
        end
    end

    assign w_issue  = (r_state == ST_READ || r_state == ST_WRITE) && !hold && (r_k < r_len);
    assign w_rd_fin = (r_state == ST_READ) && !hold && (r_k == r_len) && !w_discard;
    assign w_wr_fin = (r_state == ST_WRITE) && !hold &&
                      ((r_len == '0) || (r_k == r_len - 1'b1));

    assign mem_a    = w_issue ? r_addr + ADDR_W'(r_k) : '0;
    assign mem_wr   = w_issue && (r_state == ST_WRITE);
    assign mem_dout = mem_wr ? w_byte : 8'h00;

    // Result as it will look once this cycle's in-flight byte lands, extended
    always_comb begin
        w_byte  = 8'h00;
        w_final = r_buf;
        w_sgn   = 1'b0;
        w_ext   = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (len_t'(i) == r_k)
                w_byte = r_buf[8*i +: 8];
            if (r_pend && len_t'(i) == r_pidx)
                w_final[8*i +: 8] = mem_din;
        end
        for (int i = 0; i < MAX_LEN; i++)
            if (len_t'(i + 1) == r_len)
                w_sgn = r_signed & w_final[8*i + 7];
        for (int i = 0; i < MAX_LEN; i++)
            w_ext[8*i +: 8] = (len_t'(i) < r_len) ? w_final[8*i +: 8] : {8{w_sgn}};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_addr    <= '0;
            r_len     <= '0;
            r_k       <= '0;
            r_pidx    <= '0;
            r_signed  <= 1'b0;
            r_pend    <= 1'b0;
            r_id      <= '0;
            r_buf     <= '0;
            r_rd_data <= '0;
            r_rd_done <= '0;
            r_wr_done <= 1'b0;
        end else begin
            if (!hold) begin
                r_rd_done <= '0;
                r_wr_done <= 1'b0;
            end
            r_pend <= 1'b0;
            if (r_pend && !w_discard)
                for (int i = 0; i < MAX_LEN; i++)
                    if (len_t'(i) == r_pidx)
                        r_buf[8*i +: 8] <= mem_din;
            case (r_state)
                ST_IDLE: begin
                    if (w_wr_go) begin
                        r_state <= ST_WRITE;
                        r_addr  <= wr_addr;
                        r_len   <= clamp_len(wr_len, MAX_LEN);
                        r_buf   <= wr_data;
                        r_k     <= '0;
                    end else if (w_rd_go) begin
                        r_state  <= ST_READ;
                        r_addr   <= w_gnt_addr;
                        r_len    <= clamp_len(w_gnt_len, MAX_LEN);
                        r_signed <= w_gnt_sgn;
                        r_id     <= w_gnt_id;
                        r_buf    <= '0;
                        r_k      <= '0;
                    end
                end
                ST_READ: begin
                    if (w_discard) begin
                        r_state <= ST_IDLE;
                    end else begin
                        if (w_issue) begin
                            r_k    <= r_k + 1'b1;
                            r_pend <= 1'b1;
                            r_pidx <= r_k;
                        end
                        if (w_rd_fin) begin
                            r_state   <= ST_IDLE;
                            r_rd_data <= w_ext;
                            for (int i = 0; i < NUM_RD; i++)
                                if (ID_W'(i) == r_id)
                                    r_rd_done[i] <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    if (w_issue)
                        r_k <= r_k + 1'b1;
                    if (w_wr_fin) begin
                        r_state   <= ST_IDLE;
                        r_wr_done <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_arbiter_n
// Description : Directed, table-driven self-checking bench for ram_arbiter_n.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter_n;

    localparam int NRD = 2;
    localparam int AW  = 32;
    localparam int ML  = 4;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            hold = 1'b0;
    logic [NRD-1:0]  rd_req = '0, rd_signed = '0, rd_discard = '0, rd_done;
    logic [NRD*AW-1:0] rd_addr = '0;
    logic [NRD*3-1:0]  rd_len = '0;
    logic [8*ML-1:0] rd_data, wr_data = '0;
    logic            wr_req = 1'b0, wr_done, mem_wr;
    logic [AW-1:0]   wr_addr = '0, mem_a;
    logic [2:0]      wr_len = '0;
    logic [7:0]      mem_dout, mem_din = 8'h00;

    int errors = 0;
    int checks = 0;

    logic [7:0] ram [logic [31:0]];

    ram_arbiter_n #(.NUM_RD(NRD), .ADDR_W(AW), .MAX_LEN(ML)) dut (
        .clock(clock), .reset(reset), .hold(hold),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len),
        .rd_signed(rd_signed), .rd_discard(rd_discard), .rd_done(rd_done),
        .rd_data(rd_data), .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len),
        .wr_data(wr_data), .wr_done(wr_done), .mem_a(mem_a), .mem_wr(mem_wr),
        .mem_dout(mem_dout), .mem_din(mem_din)
    );

    always #5 clock = ~clock;

    // RAM: read byte appears the cycle after its address
    always @(posedge clock)
        mem_din <= ram.exists(mem_a) ? ram[mem_a] : 8'h00;

    typedef struct {
        int          ch;
        logic [31:0] addr;
        logic [2:0]  len;
        logic        sgn;
        logic [31:0] bytes;
        logic [31:0] exp;
    } rvec_t;

    rvec_t vt [8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic setup_rd(input int ch, input logic [31:0] a, input logic [2:0] l, input logic s);
        rd_addr[ch*AW +: AW] = a;
        rd_len[ch*3 +: 3]    = l;
        rd_signed[ch]        = s;
    endtask

    task automatic do_read(input string nm, input int ch, input logic [31:0] a, input logic [2:0] l,
                           input logic s, input logic [31:0] bytes, input logic [31:0] exp);
        int eff;
        logic [31:0] ea;
        eff = (int'(l) > ML) ? ML : int'(l);
        for (int i = 0; i < eff; i++) begin
            ea = a + 32'(i);
            ram[ea] = bytes[8*i +: 8];
        end
        step();
        setup_rd(ch, a, l, s);
        rd_req[ch] = 1'b1;
        #1;
        for (int c = 1; c <= eff + 1; c++) begin
            step();
            ea = (c <= eff) ? a + 32'(c - 1) : 32'h0;
            chk($sformatf("%s_mem_a_c%0d", nm, c), 64'(mem_a), 64'(ea));
            chk($sformatf("%s_mem_wr_c%0d", nm, c), 64'(mem_wr), 64'd0);
            chk($sformatf("%s_early_done_c%0d", nm, c), 64'(rd_done), 64'd0);
        end
        step();
        chk($sformatf("%s_done", nm), 64'(rd_done), 64'(2'b01 << ch));
        chk($sformatf("%s_data", nm), 64'(rd_data), 64'(exp));
        rd_req[ch] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int first;
        vt[0] = '{0, 32'h0000_0100, 3'd4, 1'b0, 32'h4433_2211, 32'h4433_2211};
        vt[1] = '{1, 32'h0000_0020, 3'd1, 1'b1, 32'h0000_0080, 32'hFFFF_FF80};
        vt[2] = '{1, 32'h0000_0020, 3'd1, 1'b0, 32'h0000_0080, 32'h0000_0080};
        vt[3] = '{0, 32'h0000_0200, 3'd2, 1'b1, 32'h0000_F234, 32'hFFFF_F234};
        vt[4] = '{1, 32'h0000_0300, 3'd3, 1'b0, 32'h0083_0201, 32'h0083_0201};
        vt[5] = '{0, 32'h0000_0040, 3'd0, 1'b1, 32'h0000_0000, 32'h0000_0000};
        vt[6] = '{1, 32'h0000_0400, 3'd7, 1'b1, 32'hDDCC_BBAA, 32'hDDCC_BBAA};
        vt[7] = '{0, 32'hFFFF_FFFF, 3'd3, 1'b1, 32'h0083_0201, 32'hFF83_0201};

        // Reset state
        step(); step();
        chk("rst_rd_done", 64'(rd_done), 64'd0);
        chk("rst_wr_done", 64'(wr_done), 64'd0);
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        chk("rst_mem_a", 64'(mem_a), 64'd0);
        chk("rst_mem_wr", 64'(mem_wr), 64'd0);
        chk("rst_mem_dout", 64'(mem_dout), 64'd0);
        reset = 1'b1;
        step();

        for (int v = 0; v < 8; v++)
            do_read($sformatf("vec%0d", v), vt[v].ch, vt[v].addr, vt[v].len,
                    vt[v].sgn, vt[v].bytes, vt[v].exp);

        // Write and read requested together: write goes first
        ram[32'h500] = 8'h5A;
        step();
        wr_req = 1'b1; wr_addr = 32'h0003_0000; wr_len = 3'd2; wr_data = 32'h0000_BEEF;
        setup_rd(0, 32'h500, 3'd1, 1'b0);
        rd_req[0] = 1'b1;
        step();
        chk("wr_c1_wr", 64'(mem_wr), 64'd1);
        chk("wr_c1_a", 64'(mem_a), 64'h30000);
        chk("wr_c1_dout", 64'(mem_dout), 64'hEF);
        chk("wr_c1_done", 64'(wr_done), 64'd0);
        step();
        chk("wr_c2_wr", 64'(mem_wr), 64'd1);
        chk("wr_c2_a", 64'(mem_a), 64'h30001);
        chk("wr_c2_dout", 64'(mem_dout), 64'hBE);
        chk("wr_c2_done", 64'(wr_done), 64'd0);
        step();
        chk("wr_c3_done", 64'(wr_done), 64'd1);
        chk("wr_c3_wr", 64'(mem_wr), 64'd0);
        wr_req = 1'b0;
        step();
        chk("wr_then_rd_a", 64'(mem_a), 64'h500);
        chk("wr_then_rd_wr", 64'(mem_wr), 64'd0);
        step(); step();
        chk("wr_then_rd_done", 64'(rd_done), 64'b01);
        chk("wr_then_rd_data", 64'(rd_data), 64'h5A);
        rd_req[0] = 1'b0;

        // Discard of an active L=4 read at T+2, channel 1 waiting
        step();
        setup_rd(0, 32'h100, 3'd4, 1'b0);
        rd_req[0] = 1'b1;
        step();
        setup_rd(1, 32'h20, 3'd1, 1'b0);
        rd_req[1] = 1'b1;
        step();
        rd_discard[0] = 1'b1;
        rd_req[0] = 1'b0;
        step();
        rd_discard[0] = 1'b0;
        #1;
        chk("disc_c3_wr", 64'(mem_wr), 64'd0);
        chk("disc_c3_a", 64'(mem_a), 64'd0);
        chk("disc_c3_done", 64'(rd_done), 64'd0);
        step();
        chk("disc_c4_a", 64'(mem_a), 64'h20);
        chk("disc_c4_done", 64'(rd_done), 64'd0);
        step();
        chk("disc_c5_done", 64'(rd_done), 64'd0);
        step();
        chk("disc_c6_done", 64'(rd_done), 64'b10);
        chk("disc_c6_data", 64'(rd_data), 64'h80);
        rd_req[1] = 1'b0;

        // Hold for 3 cycles after the second byte is issued
        step();
        setup_rd(0, 32'h100, 3'd4, 1'b0);
        rd_req[0] = 1'b1;
        step();
        chk("hold_c1_a", 64'(mem_a), 64'h100);
        step();
        chk("hold_c2_a", 64'(mem_a), 64'h101);
        for (int c = 3; c <= 5; c++) begin
            step();
            hold = 1'b1;
            #1;
            chk($sformatf("hold_c%0d_a", c), 64'(mem_a), 64'd0);
            chk($sformatf("hold_c%0d_wr", c), 64'(mem_wr), 64'd0);
            chk($sformatf("hold_c%0d_done", c), 64'(rd_done), 64'd0);
        end
        step();
        hold = 1'b0;
        #1;
        chk("hold_c6_a", 64'(mem_a), 64'h102);
        step();
        chk("hold_c7_a", 64'(mem_a), 64'h103);
        step();
        chk("hold_c8_a", 64'(mem_a), 64'd0);
        chk("hold_c8_done", 64'(rd_done), 64'd0);
        step();
        chk("hold_c9_done", 64'(rd_done), 64'b01);
        chk("hold_c9_data", 64'(rd_data), 64'h4433_2211);
        rd_req[0] = 1'b0;

        // Done pulse deferred by hold
        step();
        setup_rd(1, 32'h20, 3'd1, 1'b1);
        rd_req[1] = 1'b1;
        step(); step();
        step();
        hold = 1'b1;
        #1;
        chk("hdone_c3", 64'(rd_done), 64'd0);
        step();
        chk("hdone_c4", 64'(rd_done), 64'd0);
        step();
        hold = 1'b0;
        #1;
        chk("hdone_c5", 64'(rd_done), 64'b10);
        chk("hdone_c5_data", 64'(rd_data), 64'hFFFF_FF80);
        rd_req[1] = 1'b0;

        // Arbitration: last read grant was channel 0 before both request together
        do_read("pre_arb", 0, 32'h0000_0100, 3'd1, 1'b0, 32'h11, 32'h11);
        ram[32'h600] = 8'h06;
        ram[32'h700] = 8'h07;
`ifdef ARB_ROUND_ROBIN_EN
        first = 1;
`else
        first = 0;
`endif
        step();
        setup_rd(0, 32'h600, 3'd1, 1'b0);
        setup_rd(1, 32'h700, 3'd1, 1'b0);
        rd_req = 2'b11;
        step();
        chk("arb_first_a", 64'(mem_a), (first == 0) ? 64'h600 : 64'h700);
        step(); step();
        chk("arb_first_done", 64'(rd_done), 64'(2'b01 << first));
        chk("arb_first_data", 64'(rd_data), (first == 0) ? 64'h06 : 64'h07);
        step();
        chk("arb_second_a", 64'(mem_a), (first == 0) ? 64'h700 : 64'h600);
        step(); step();
        chk("arb_second_done", 64'(rd_done), 64'(2'b01 << (1 - first)));
        chk("arb_second_data", 64'(rd_data), (first == 0) ? 64'h07 : 64'h06);
        rd_req = 2'b00;

        // Reset mid-transfer aborts with no done afterwards
        step();
        setup_rd(0, 32'h100, 3'd4, 1'b0);
        rd_req[0] = 1'b1;
        step(); step();
        reset = 1'b0;
        rd_req[0] = 1'b0;
        #1;
        chk("rstmid_a", 64'(mem_a), 64'd0);
        chk("rstmid_data", 64'(rd_data), 64'd0);
        step();
        reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            chk($sformatf("rstmid_done_c%0d", c), 64'(rd_done), 64'd0);
            chk($sformatf("rstmid_a_c%0d", c), 64'(mem_a), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ram_arbiter_n.md
Name: ram_arbiter_n

Overview:
- Parametrised byte-serial RAM arbiter. Successor to the fixed two-reader/one-writer memory controller.
- Serves NUM_RD read channels (I-cache, D-cache, future prefetcher) and one write channel (store buffer).
- Drives the 8-bit RAM bus: read data returns the cycle after its address, a write completes in one cycle. Assembles multi-byte little-endian transfers.

Parameters:
- NUM_RD, 2: number of read channels (1..8).
- ADDR_W, 32: address width.
- MAX_LEN, 4: maximum transfer bytes. Data buses are 8*MAX_LEN wide.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- hold  in  1  pause: freeze issue (rdy low)
- rd_req  in  NUM_RD  read request per channel, held until rd_done
- rd_addr  in  NUM_RD*ADDR_W  start address per channel
- rd_len  in  NUM_RD*3  byte count per channel
- rd_signed  in  NUM_RD  sign-extend result
- rd_discard  in  NUM_RD  abort the channel's active read
- rd_done  out  NUM_RD  one-cycle completion pulse
- rd_data  out  8*MAX_LEN  shared read result, valid with rd_done
- wr_req  in  1  write request, held until wr_done
- wr_addr  in  ADDR_W  write address
- wr_len  in  3  write byte count
- wr_data  in  8*MAX_LEN  write data, little-endian
- wr_done  out  1  one-cycle completion pulse
- mem_a  out  ADDR_W  RAM address
- mem_wr  out  1  1 = write
- mem_dout  out  8  RAM write byte
- mem_din  in  8  RAM read byte

Behaviour:
- Reset (reset=0, async): state IDLE; all counters 0; rd_done=0, wr_done=0, rd_data=0, mem_a=0, mem_wr=0, mem_dout=0.
- FSM states: IDLE, READ, WRITE.
- IDLE grant:
  - wr_req has priority over all reads.
  - Otherwise one read channel is picked by the arbitration policy (see Optional Feature).
  - A channel whose done pulses this cycle is excluded from the grant.
  - Grant latches addr, len, signed and channel id; byte counter k=0.
- READ, request granted in cycle T, length L:
  - Cycles T+1..T+L: mem_a=addr+k, mem_wr=0.
  - Byte k is captured from mem_din in cycle T+2+k into byte lane k.
  - Cycle T+L+1: the last byte is captured and state returns to IDLE.
  - Cycle T+L+2: rd_done[id]=1. rd_data holds the zero- or sign-extended result (sign bit = bit 8L-1).
- WRITE:
  - Cycles T+1..T+L: mem_wr=1, mem_a=addr+k, mem_dout=wr_data[8k+7:8k].
  - wr_done pulses in cycle T+L+1.
- Length rules:
  - Legal L is 1..MAX_LEN.
  - L=0: no bus activity, done pulses at T+2 (read data 0).
  - L>MAX_LEN is clamped to MAX_LEN.
- Address arithmetic wraps modulo 2^ADDR_W.
- Idle or inactive outputs: mem_wr=0, mem_a=0, mem_dout=0.
- Discard:
  - rd_discard[id] during READ: state returns to IDLE at the next edge, no rd_done, in-flight byte dropped.
  - Discard of a non-active channel is ignored.
  - Writes cannot be discarded.
- Hold:
  - While hold=1, the state and counter k freeze and mem_wr is forced to 0.
  - A byte issued in the cycle before hold rose is still captured (pending-capture flag). After hold falls, that byte is not re-issued.
  - Done pulses are not emitted during hold; they are deferred to the first cycle with hold=0.
- Simultaneous events:
  - discard and completion in the same cycle: discard wins.
  - wr_req and rd_req arrive together: write first.
- Reset asserted mid-transfer aborts immediately; no done pulses follow.

Optional Feature:
- ARB_ROUND_ROBIN_EN defined: round-robin among read channels. A pointer advances to (last granted id + 1) mod NUM_RD after each read grant; the pointer resets to 0.
- Undefined: fixed priority, lowest index wins.
- Write priority is unchanged in both modes.

Decomposition:
- Shared package/define file: ADDR_W default, MAX_LEN, length encoding, state encodings (IDLE/READ/WRITE), IO region constant (addr[17:16]==2'b11).
- One natural sub-module, rr_arbiter: NUM_RD-bit request vector in, one-hot grant out, macro-selected policy, pointer register inside.

Test Plan:
- Ch0 reads L=4 at 0x100, mem returns 0x11,0x22,0x33,0x44 -> mem_a 0x100..0x103 in T+1..T+4; rd_done[0] at T+6; rd_data=0x44332211.
- Ch1 reads L=1 signed at 0x20, byte 0x80 -> rd_data=0xFFFFFF80. The same read unsigned -> rd_data=0x00000080.
- wr_req L=2 addr 0x30000 data 0xBEEF and rd_req[0] in the same cycle -> write first: mem_wr=1 with 0xEF then 0xBE; wr_done at T+3; then the read is granted.
- rd_discard[0] raised at T+2 of an L=4 read -> mem_wr=0, mem_a=0 from T+3; no rd_done; a pending rd_req[1] is granted at T+3.
- rd_req=2'b11 held, each channel re-requesting after done -> with ARB_ROUND_ROBIN_EN grants alternate 0,1,0,1; without it channel 0 starves channel 1 only while re-requesting.
- hold=1 for 3 cycles after the second byte is issued -> the second byte is still captured, no mem_a advance during hold, the transfer completes correctly 3 cycles late.
